rr_encoder_arbiter: RTL

Round-robin arbiter that shares the 4-input one-hot encoder path between NUM_REQ requesters.
- Converts raw, possibly multi-hot requests into a registered, strictly one-hot grant, so the downstream encoder only ever sees legal codes.
- Supplies the matching binary grant index directly.
- Holds a grant until the owner finishes or releases it, or a hold timeout expires. It then rotates priority so no requester can starve.

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_pick_comb.sv | 37 +++
 rtl/rr_encoder_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin encoder arbiter.
// onehot_to_idx uses the same one-hot to binary mapping as the encoder.
package arb_pkg;

  localparam int NUM_REQ  = 4;
  localparam int IDX_W    = $clog2(NUM_REQ);
  localparam int MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   idx_t;

  function automatic idx_t onehot_to_idx(input req_vec_t v);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) idx = idx | idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin pick: rotate the requests so the search starts
// at last_ptr+1, take the lowest set bit, then rotate the one-hot back.
module rr_pick_comb
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  idx_t     last_ptr,
  output req_vec_t pick,
  output idx_t     pick_idx
);

  int                       start;
  logic [2*NUM_REQ-1:0]     fwd;
  logic [2*NUM_REQ-1:0]     back;
  req_vec_t                 rot;
  req_vec_t                 rot_pick;
  logic                     found;

  always_comb begin
    start    = (int'(last_ptr) + 1) % NUM_REQ;
    fwd      = {req, req} >> start;
    rot      = fwd[NUM_REQ-1:0];
    rot_pick = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rot[i] && !found) begin
        rot_pick[i] = 1'b1;
        found       = 1'b1;
      end
    end
    // The upper half of the doubled vector holds the rotate-back result.
    back     = {rot_pick, rot_pick} << start;
    pick     = back[2*NUM_REQ-1:NUM_REQ];
    pick_idx = onehot_to_idx(pick);
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter delivering a registered one-hot grant and its index.
// Handshake: req[n] must stay high for as long as requester n wants the grant; done releases it.
module rr_encoder_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = arb_pkg::MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic             done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output arb_state_e       dbg_state
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  idx_t              last_ptr_q, last_ptr_d;
  req_vec_t          gnt_q, gnt_d;
  idx_t              gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;

  req_vec_t          pick;
  idx_t              pick_idx;
  logic              owner_req;
  logic              at_limit;
  logic              release_now;

  rr_pick_comb u_pick (
    .req      (req),
    .last_ptr (last_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign owner_req   = req[gnt_idx_q];
  assign at_limit    = (hold_cnt_q == HOLD_LAST);
  assign release_now = done || !owner_req || at_limit;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    last_ptr_d  = last_ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          gnt_d       = pick;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          last_ptr_d  = gnt_idx_q;
          // Pulse only when the hold limit alone forced the release.
          timeout_d   = at_limit && !done && owner_req;
        end else begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      last_ptr_q  <= idx_t'(NUM_REQ - 1);
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_ptr_q  <= last_ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule
